// File: rtl/sp_pkg.sv
// Shared types and widths for the simple processor: opcodes, controller states, ALU selects.
package sp_pkg;
    localparam int IW  = 16;
    localparam int PCW = 7;
    localparam int DAW = 8;
    localparam int RAW = 4;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_JUMP  = 4'd6
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_LOAD_IR = 4'd2,
        S_DECODE  = 4'd3,
        S_NOOP    = 4'd4,
        S_STORE   = 4'd5,
        S_LOAD_A  = 4'd6,
        S_LOAD_B  = 4'd7,
        S_ADD     = 4'd8,
        S_SUB     = 4'd9,
        S_HALT    = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
endpackage

// File: rtl/control_unit_if.sv
// Controller-to-PC/ROM/datapath bundle; master is the control unit.
interface control_unit_if;
    import sp_pkg::*;

    logic [IW-1:0]  IR_in;
    logic           PC_up;
    logic           PC_clr;
    logic           PC_jmp_en;
    logic [PCW-1:0] PC_jmp_addr;
    logic [DAW-1:0] D_addr;
    logic           D_wr;
    logic           RF_s;
    logic [RAW-1:0] RF_W_addr;
    logic           RF_W_en;
    logic [RAW-1:0] RF_Ra_addr;
    logic [RAW-1:0] RF_Rb_addr;
    logic [2:0]     ALU_s0;
    logic [3:0]     state_out;

    modport master (
        input  IR_in,
        output PC_up, PC_clr, PC_jmp_en, PC_jmp_addr, D_addr, D_wr, RF_s,
               RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out
    );

    modport slave (
        output IR_in,
        input  PC_up, PC_clr, PC_jmp_en, PC_jmp_addr, D_addr, D_wr, RF_s,
               RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out
    );
endinterface

// File: rtl/ir_reg.sv
// Instruction register: load-enabled, synchronous clear has priority over load.
module ir_reg
    import sp_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          ld,
    input  logic [IW-1:0] d,
    output logic [IW-1:0] q
);
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetch/decode/execute with Moore outputs from state and IR.
module control_unit
    import sp_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset,
    control_unit_if.master bus
);
    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ir;
    logic          ir_ld;

    ir_reg u_ir (
        .clk (Clk),
        .clr (Reset),
        .ld  (ir_ld),
        .d   (bus.IR_in),
        .q   (ir)
    );

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        ir_ld           = 1'b0;
        bus.PC_up       = 1'b0;
        bus.PC_clr      = 1'b0;
        bus.PC_jmp_en   = 1'b0;
        bus.PC_jmp_addr = '0;
        bus.D_addr      = '0;
        bus.D_wr        = 1'b0;
        bus.RF_s        = 1'b0;
        bus.RF_W_addr   = '0;
        bus.RF_W_en     = 1'b0;
        bus.RF_Ra_addr  = '0;
        bus.RF_Rb_addr  = '0;
        bus.ALU_s0      = ALU_PASS;
        bus.state_out   = state;

        case (state)
            S_INIT: begin
                bus.PC_clr = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_FETCH: state_nxt = S_LOAD_IR;
            S_LOAD_IR: begin
                ir_ld     = 1'b1;
                bus.PC_up = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (ir[15:12])
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
                    OP_JUMP:  state_nxt = S_JUMP;
                    default:  state_nxt = S_FETCH;
                endcase
            end
            S_STORE: begin
                bus.D_addr     = ir[7:0];
                bus.RF_Ra_addr = ir[11:8];
                bus.D_wr       = 1'b1;
                state_nxt      = S_FETCH;
            end
            // RAM read data is valid one cycle after the address is presented.
            S_LOAD_A: begin
                bus.D_addr = ir[7:0];
                state_nxt  = S_LOAD_B;
            end
            S_LOAD_B: begin
                bus.D_addr    = ir[7:0];
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = ir[11:8];
                bus.RF_W_en   = 1'b1;
                state_nxt     = S_FETCH;
            end
            S_ADD, S_SUB: begin
                bus.RF_Ra_addr = ir[7:4];
                bus.RF_Rb_addr = ir[3:0];
                bus.RF_W_addr  = ir[11:8];
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state == S_ADD) ? ALU_ADD : ALU_SUB;
                state_nxt      = S_FETCH;
            end
            S_JUMP: begin
                bus.PC_jmp_en   = 1'b1;
                bus.PC_jmp_addr = ir[6:0];
                state_nxt       = S_FETCH;
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_INIT;
        endcase

        // Reset masks everything so an in-flight store or register write is dropped.
        if (Reset) begin
            ir_ld           = 1'b0;
            bus.PC_up       = 1'b0;
            bus.PC_clr      = 1'b1;
            bus.PC_jmp_en   = 1'b0;
            bus.PC_jmp_addr = '0;
            bus.D_addr      = '0;
            bus.D_wr        = 1'b0;
            bus.RF_s        = 1'b0;
            bus.RF_W_addr   = '0;
            bus.RF_W_en     = 1'b0;
            bus.RF_Ra_addr  = '0;
            bus.RF_Rb_addr  = '0;
            bus.ALU_s0      = ALU_PASS;
            bus.state_out   = S_INIT;
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, each opcode class, reset mid-store, halt hold.
module tb_control_unit;
    import sp_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    control_unit_if bus ();

    control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // {PC_up, PC_clr, PC_jmp_en, D_wr, RF_W_en, RF_s}
    logic [5:0] en;
    assign en = {bus.PC_up, bus.PC_clr, bus.PC_jmp_en, bus.D_wr, bus.RF_W_en, bus.RF_s};

    task automatic tick();
        @(negedge Clk);
    endtask

    // Drive an instruction from FETCH and advance into its first execute state.
    task automatic issue(input logic [15:0] instr);
        bus.IR_in = instr;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.IR_in = 16'h0000;
        repeat (2) tick();
        checks++; if (bus.state_out !== 4'd0 || en !== 6'b010000) begin failures++;
            $display("FAIL reset_hold state=%0d en=%b exp state=0 en=010000", bus.state_out, en); end
        checks++; if (dut.ir !== 16'h0000) begin failures++;
            $display("FAIL reset_ir got=%h exp=0000", dut.ir); end
        Reset = 1'b0;
        #1;
        checks++; if (bus.state_out !== 4'd0 || en !== 6'b010000) begin failures++;
            $display("FAIL post_reset_init state=%0d en=%b exp state=0 en=010000", bus.state_out, en); end
        tick();
        checks++; if (bus.state_out !== 4'd1 || en !== 6'b000000) begin failures++;
            $display("FAIL reset_fetch state=%0d en=%b exp state=1 en=000000", bus.state_out, en); end
        tick();
        checks++; if (bus.state_out !== 4'd2 || en !== 6'b100000) begin failures++;
            $display("FAIL reset_load_ir state=%0d en=%b exp state=2 en=100000", bus.state_out, en); end
        tick();
        checks++; if (bus.state_out !== 4'd3 || en !== 6'b000000) begin failures++;
            $display("FAIL reset_decode state=%0d en=%b exp state=3 en=000000", bus.state_out, en); end
        tick();
        checks++; if (bus.state_out !== 4'd1) begin failures++;
            $display("FAIL noop_return state=%0d exp=1", bus.state_out); end
    endtask

    task automatic test_add();
        issue(16'h3512);
        checks++; if (bus.state_out !== 4'd8 || en !== 6'b000010) begin failures++;
            $display("FAIL add_state state=%0d en=%b exp state=8 en=000010", bus.state_out, en); end
        checks++; if ({bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.ALU_s0} !== {4'd1, 4'd2, 4'd5, 3'd1}) begin failures++;
            $display("FAIL add_fields ra=%0d rb=%0d w=%0d alu=%0d exp 1 2 5 1",
                     bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.ALU_s0); end
        tick();
        checks++; if (bus.state_out !== 4'd1 || en !== 6'b000000) begin failures++;
            $display("FAIL add_return state=%0d en=%b exp state=1 en=000000", bus.state_out, en); end
    endtask

    task automatic test_sub();
        issue(16'h4123);
        checks++; if (bus.state_out !== 4'd9 || en !== 6'b000010) begin failures++;
            $display("FAIL sub_state state=%0d en=%b exp state=9 en=000010", bus.state_out, en); end
        checks++; if ({bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.ALU_s0} !== {4'd2, 4'd3, 4'd1, 3'd2}) begin failures++;
            $display("FAIL sub_fields ra=%0d rb=%0d w=%0d alu=%0d exp 2 3 1 2",
                     bus.RF_Ra_addr, bus.RF_Rb_addr, bus.RF_W_addr, bus.ALU_s0); end
        tick();
    endtask

    task automatic test_load();
        issue(16'h2A1F);
        checks++; if (bus.state_out !== 4'd6 || en !== 6'b000000 || bus.D_addr !== 8'h1F) begin failures++;
            $display("FAIL load_a state=%0d en=%b addr=%h exp state=6 en=000000 addr=1f",
                     bus.state_out, en, bus.D_addr); end
        tick();
        checks++; if (bus.state_out !== 4'd7 || en !== 6'b000011 || bus.D_addr !== 8'h1F) begin failures++;
            $display("FAIL load_b state=%0d en=%b addr=%h exp state=7 en=000011 addr=1f",
                     bus.state_out, en, bus.D_addr); end
        checks++; if (bus.RF_W_addr !== 4'hA) begin failures++;
            $display("FAIL load_waddr got=%0d exp=10", bus.RF_W_addr); end
        tick();
        checks++; if (bus.state_out !== 4'd1) begin failures++;
            $display("FAIL load_return state=%0d exp=1", bus.state_out); end
    endtask

    task automatic test_store();
        issue(16'h1340);
        checks++; if (bus.state_out !== 4'd5 || en !== 6'b000100) begin failures++;
            $display("FAIL store_state state=%0d en=%b exp state=5 en=000100", bus.state_out, en); end
        checks++; if (bus.D_addr !== 8'h40 || bus.RF_Ra_addr !== 4'd3) begin failures++;
            $display("FAIL store_fields addr=%h ra=%0d exp addr=40 ra=3", bus.D_addr, bus.RF_Ra_addr); end
        tick();
    endtask

    task automatic test_store_reset();
        issue(16'h1340);
        Reset = 1'b1;
        #1;
        checks++; if (bus.D_wr !== 1'b0 || en !== 6'b010000) begin failures++;
            $display("FAIL store_reset_mask d_wr=%b en=%b exp d_wr=0 en=010000", bus.D_wr, en); end
        tick();
        checks++; if (bus.state_out !== 4'd0 || dut.ir !== 16'h0000) begin failures++;
            $display("FAIL store_reset_after state=%0d ir=%h exp state=0 ir=0000", bus.state_out, dut.ir); end
        Reset = 1'b0;
        tick();
        checks++; if (bus.state_out !== 4'd1) begin failures++;
            $display("FAIL store_reset_fetch state=%0d exp=1", bus.state_out); end
    endtask

    task automatic test_jump();
        issue(16'h6045);
        checks++; if (bus.state_out !== 4'd11 || en !== 6'b001000 || bus.PC_jmp_addr !== 7'h45) begin failures++;
            $display("FAIL jump_state state=%0d en=%b tgt=%h exp state=11 en=001000 tgt=45",
                     bus.state_out, en, bus.PC_jmp_addr); end
        tick();
        checks++; if (bus.state_out !== 4'd1 || bus.PC_jmp_en !== 1'b0) begin failures++;
            $display("FAIL jump_return state=%0d jmp_en=%b exp state=1 jmp_en=0", bus.state_out, bus.PC_jmp_en); end
        issue(16'h6FC5);
        checks++; if (bus.state_out !== 4'd11 || bus.PC_jmp_addr !== 7'h45) begin failures++;
            $display("FAIL jump_unused_bits state=%0d tgt=%h exp state=11 tgt=45", bus.state_out, bus.PC_jmp_addr); end
        tick();
        bus.IR_in = 16'h7000;
        tick();
        tick();
        checks++; if (bus.state_out !== 4'd3 || en !== 6'b000000) begin failures++;
            $display("FAIL undef_decode state=%0d en=%b exp state=3 en=000000", bus.state_out, en); end
        tick();
        checks++; if (bus.state_out !== 4'd1 || en !== 6'b000000) begin failures++;
            $display("FAIL undef_noop state=%0d en=%b exp state=1 en=000000", bus.state_out, en); end
    endtask

    task automatic test_halt();
        issue(16'h5000);
        for (int i = 0; i < 50; i++) begin
            checks++; if (bus.state_out !== 4'd10 || en !== 6'b000000) begin failures++;
                $display("FAIL halt_hold cyc=%0d state=%0d en=%b exp state=10 en=000000", i, bus.state_out, en); end
            tick();
        end
        Reset = 1'b1;
        tick();
        checks++; if (bus.state_out !== 4'd0 || en !== 6'b010000) begin failures++;
            $display("FAIL halt_reset state=%0d en=%b exp state=0 en=010000", bus.state_out, en); end
        Reset = 1'b0;
        tick();
        checks++; if (bus.state_out !== 4'd1) begin failures++;
            $display("FAIL halt_restart state=%0d exp=1", bus.state_out); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IR_in = 16'h0000;
        test_reset();
        test_add();
        test_sub();
        test_load();
        test_store();
        test_store_reset();
        test_jump();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction-sequencing FSM for the simple processor; it is the master side of the program-counter interface.
- Drives PC_up/PC_clr (and a jump load) to the 7-bit PC.
- Captures the 16-bit instruction that instruction ROM returns for PCout, decodes it, and issues data-memory, register-file and ALU controls.
- Sits between ROM/PC and the datapath (data RAM, register file, ALU).

Parameters:
- IW, 16, instruction width.
- PCW, 7, program address width; must match PC output.
- DAW, 8, data-memory address width.
- RAW, 4, register-file address width.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- IR_in  in  16  ROM read data for address PCout; one-cycle synchronous read latency.
- PC_up  out  1  increment PC at next edge.
- PC_clr  out  1  clear PC to 0 at next edge.
- PC_jmp_en  out  1  load PC with PC_jmp_addr at next edge; companion PC revision gives priority PC_clr > PC_jmp_en > PC_up.
- PC_jmp_addr  out  7  jump target.
- D_addr  out  8  data RAM address.
- D_wr  out  1  data RAM write enable.
- RF_s  out  1  register-file write-data mux; 1 = RAM data, 0 = ALU result.
- RF_W_addr  out  4  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  4  register-file read port A address.
- RF_Rb_addr  out  4  register-file read port B address.
- ALU_s0  out  3  ALU select: 0 pass-A, 1 add, 2 sub.
- state_out  out  4  current state encoding, for debug and hex display.

Behaviour:
- Internal registers: state, and 16-bit IR. Both reset to INIT and 16'h0000 respectively.
- Outputs are a Moore decode of state and IR.
- While Reset=1, outputs are forced to INIT values regardless of current state, so no stray D_wr or RF_W_en occurs in the reset cycle.
- INIT values: PC_clr=1. All other outputs are 0.
- Instruction format: opcode IR[15:12]; Rd/Ra IR[11:8]; direct address IR[7:0]; ADD/SUB sources IR[7:4] and IR[3:0]; jump target IR[6:0].
- Opcodes: 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT, 6 JUMP. Codes 7..15 execute as NOOP.
- State transitions and outputs:
  - INIT: PC_clr=1 -> FETCH.
  - FETCH: no outputs asserted; covers the ROM latency for the current PCout -> LOAD_IR.
  - LOAD_IR: IR <= IR_in; PC_up=1 -> DECODE.
  - DECODE: branches on opcode to STORE, LOAD_A, ADD, SUB, HALT or JUMP. NOOP and undefined opcodes go -> FETCH.
  - STORE: D_addr=IR[7:0]; RF_Ra_addr=IR[11:8]; D_wr=1 -> FETCH.
  - LOAD_A: D_addr=IR[7:0]; covers RAM read latency -> LOAD_B.
  - LOAD_B: D_addr held; RF_s=1; RF_W_addr=IR[11:8]; RF_W_en=1 -> FETCH.
  - ADD: RF_Ra_addr=IR[7:4]; RF_Rb_addr=IR[3:0]; RF_W_addr=IR[11:8]; RF_W_en=1; ALU_s0=1; RF_s=0 -> FETCH.
  - SUB: same as ADD with ALU_s0=2 -> FETCH.
  - JUMP: PC_jmp_en=1; PC_jmp_addr=IR[6:0] -> FETCH. PC_up is not asserted.
  - HALT: all outputs 0; stays in HALT until Reset.
- Cycle cost per instruction: NOOP 3, STORE/ADD/SUB/JUMP 4, LOAD 5.
- Mutual exclusion: PC_up, PC_clr and PC_jmp_en are never asserted in the same cycle. D_wr and RF_W_en are never asserted in the same cycle.
- PC wrap: wrap-around 127 -> 0 is handled by the PC itself. The controller asserts PC_up at PCout=127 normally, and execution continues at address 0.
- Reset mid-operation: next state is INIT from any state, including HALT. IR clears. The instruction in flight is abandoned with no write.
- Unused IR bits are ignored, e.g. IR[11:7] for JUMP.
- state_out encoding: INIT 0, FETCH 1, LOAD_IR 2, DECODE 3, NOOP-unused 4, STORE 5, LOAD_A 6, LOAD_B 7, ADD 8, SUB 9, HALT 10, JUMP 11.

Decomposition:
- Shared package sp_pkg holds:
  - opcode_t enum (4-bit);
  - state_t enum (4-bit, encodings above);
  - ALU select constants ALU_PASS=0, ALU_ADD=1, ALU_SUB=2;
  - width constants IW, PCW, DAW, RAW, reused by PC, ROM and datapath.
- One natural sub-module: ir_reg, a 16-bit load-enabled register with synchronous clear. Next-state and output decode stay in control_unit.

Test Plan:
- Reset=1 for 2 cycles, then 0 -> PC_clr=1 in the first post-reset cycle; state_out sequence 0,1,2,3; PC_up=1 exactly in the LOAD_IR cycle.
- IR_in=16'h3512 (ADD R5=R1+R2) -> in the ADD state: RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=5, RF_W_en=1, ALU_s0=1, RF_s=0; back to FETCH after 4 cycles.
- IR_in=16'h2A1F (LOAD R10<-D[0x1F]) -> D_addr=0x1F in both LOAD_A and LOAD_B; RF_W_en=1 and RF_s=1 only in LOAD_B; 5-cycle instruction.
- IR_in=16'h1340 (STORE D[0x40]<-R3), with Reset pulsed during the STORE cycle -> D_wr=0 in that cycle, state_out=0 next, IR=0.
- IR_in=16'h6045 (JUMP 0x45) -> PC_jmp_en=1 and PC_jmp_addr=7'h45 for one cycle, PC_up=0 in the JUMP cycle; then IR_in=16'h7000 executes as NOOP (3 cycles, no enables).
- IR_in=16'h5000 (HALT) -> state_out stays 10 for 50 cycles with all enables 0; Reset then returns state_out to 0.
